uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_sync_2ff.sv | 15 +
 rtl/uart_rx.sv | 96 +++++++++
 tb/tb_uart_rx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and frame constants for the receiver and transmitter
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 104;
  typedef enum logic [2:0] {
    s_IDLE      = 3'd0,
    s_START     = 3'd1,
    s_DATA      = 3'd2,
    s_STOP      = 3'd3,
    s_CLEANUP   = 3'd4,
    s_WAIT_HIGH = 3'd5
  } uart_state_t;
endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, flops reset to RST_VAL
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) {q, meta} <= {RST_VAL, RST_VAL};
    else         {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-cycle valid and framing-error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Active,
  output logic                 o_Rx_Frame_Err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  uart_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, byte_n;
  logic rx_s, dv_n, ferr_n;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .d      (i_Rx_Serial),
    .q      (rx_s)
  );
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= s_IDLE;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      o_Rx_Byte      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      shreg          <= shreg_n;
      o_Rx_Byte      <= byte_n;
      o_Rx_DV        <= dv_n;
      o_Rx_Frame_Err <= ferr_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    byte_n  = o_Rx_Byte;
    dv_n    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      s_IDLE: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? s_IDLE : s_START;
      end
      s_START: if (cnt == HALF) begin
        cnt_n   = '0;
        state_n = rx_s ? s_IDLE : s_DATA;
      end
      s_DATA: if (cnt == LAST) begin
        cnt_n        = '0;
        shreg_n[idx] = rx_s;
        idx_n        = idx + 1'b1;
        state_n      = (idx == IDX_LAST) ? s_STOP : s_DATA;
      end
      s_STOP: if (cnt == LAST) begin
        cnt_n   = '0;
        dv_n    = rx_s;
        ferr_n  = !rx_s;
        byte_n  = rx_s ? shreg : o_Rx_Byte;
        state_n = rx_s ? s_CLEANUP : s_WAIT_HIGH;
      end
      s_CLEANUP: begin
        cnt_n   = '0;
        state_n = s_IDLE;
      end
      s_WAIT_HIGH: begin
        cnt_n   = '0;
        state_n = rx_s ? s_IDLE : s_WAIT_HIGH;
      end
      default: begin
        cnt_n   = '0;
        state_n = s_IDLE;
      end
    endcase
  end
  assign o_Rx_Active = (state == s_START) || (state == s_DATA) || (state == s_STOP);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at 8 clocks/bit plus one 104 clocks/bit frame
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx104 = 1'b1;
  logic dv, act, ferr, dv104, act104, ferr104;
  logic [7:0] rbyte, rbyte104;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int dv_cnt = 0, ferr_cnt = 0, both_cnt = 0, act_cnt = 0, dv_cyc = -1;
  int dv104_cnt = 0, ferr104_cnt = 0, dv104_cyc = -1;
  logic [7:0] dv_q[$];
  uart_rx #(.CLKS_PER_BIT(8)) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx),
    .o_Rx_DV(dv), .o_Rx_Byte(rbyte), .o_Rx_Active(act), .o_Rx_Frame_Err(ferr)
  );
  uart_rx #(.CLKS_PER_BIT(104)) u_dut104 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx104),
    .o_Rx_DV(dv104), .o_Rx_Byte(rbyte104), .o_Rx_Active(act104), .o_Rx_Frame_Err(ferr104)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dv) begin dv_cnt++; dv_cyc = cyc; dv_q.push_back(rbyte); end
    if (ferr) ferr_cnt++;
    if (dv && ferr) both_cnt++;
    if (act) act_cnt++;
    if (dv104) begin dv104_cnt++; dv104_cyc = cyc; end
    if (ferr104) ferr104_cnt++;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_bit(input logic v, input int n);
    rx = v;
    tick(n);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit jit, input int stop_len, input logic stop_v);
    int lens[8] = '{7, 9, 8, 9, 7, 8, 9, 7};
    send_bit(1'b0, 8);
    for (int i = 0; i < 8; i++) send_bit(b[i], jit ? lens[i] : 8);
    send_bit(stop_v, stop_len);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    total++; if (rbyte !== 8'h00) begin $display("FAIL reset_byte got=%h exp=00", rbyte); end else passed++;
    total++; if (dv !== 1'b0) begin $display("FAIL reset_dv got=%b exp=0", dv); end else passed++;
    total++; if (act !== 1'b0) begin $display("FAIL reset_active got=%b exp=0", act); end else passed++;
    total++; if (ferr !== 1'b0) begin $display("FAIL reset_ferr got=%b exp=0", ferr); end else passed++;
    total++; if (rbyte104 !== 8'h00) begin $display("FAIL reset_byte104 got=%h exp=00", rbyte104); end else passed++;
  endtask
  task automatic test_ideal;
    int d0 = dv_cnt, f0 = ferr_cnt, q0 = dv_q.size(), k = cyc;
    send_frame(8'hA5, 1'b0, 8, 1'b1);
    tick(4);
    total++; if (dv_cnt - d0 !== 1) begin $display("FAIL ideal_dv_count got=%0d exp=1", dv_cnt - d0); end else passed++;
    total++; if ((dv_q.size() > q0 ? dv_q[q0] : 8'hxx) !== 8'hA5) begin $display("FAIL ideal_strobe_byte exp=A5"); end else passed++;
    total++; if (rbyte !== 8'hA5) begin $display("FAIL ideal_byte got=%h exp=A5", rbyte); end else passed++;
    total++; if (ferr_cnt - f0 !== 0) begin $display("FAIL ideal_ferr got=%0d exp=0", ferr_cnt - f0); end else passed++;
    total++; if (dv_cyc !== k + 79) begin $display("FAIL ideal_dv_cycle got=%0d exp=%0d", dv_cyc, k + 79); end else passed++;
  endtask
  task automatic test_glitch;
    int d0 = dv_cnt, f0 = ferr_cnt, a0 = act_cnt;
    send_bit(1'b0, 2);
    send_bit(1'b1, 20);
    total++; if (act_cnt - a0 < 1 || act_cnt - a0 > 4) begin $display("FAIL glitch_active_cycles got=%0d exp=1..4", act_cnt - a0); end else passed++;
    total++; if (dv_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin $display("FAIL glitch_strobes got dv=%0d ferr=%0d exp=0", dv_cnt - d0, ferr_cnt - f0); end else passed++;
    total++; if (act !== 1'b0) begin $display("FAIL glitch_idle got=%b exp=0", act); end else passed++;
    send_frame(8'h3C, 1'b0, 8, 1'b1);
    tick(4);
    total++; if (dv_cnt - d0 !== 1) begin $display("FAIL glitch_next_dv got=%0d exp=1", dv_cnt - d0); end else passed++;
    total++; if (rbyte !== 8'h3C) begin $display("FAIL glitch_next_byte got=%h exp=3C", rbyte); end else passed++;
  endtask
  task automatic test_frame_err;
    int d0 = dv_cnt, f0 = ferr_cnt, a0;
    send_bit(1'b0, 8);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 8);
    send_bit(1'b0, 10);
    a0 = act_cnt;
    send_bit(1'b0, 30);
    total++; if (act_cnt - a0 !== 0) begin $display("FAIL ferr_wait_active got=%0d exp=0", act_cnt - a0); end else passed++;
    total++; if (ferr_cnt - f0 !== 1) begin $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end else passed++;
    send_bit(1'b1, 20);
    total++; if (dv_cnt - d0 !== 0) begin $display("FAIL ferr_dv got=%0d exp=0", dv_cnt - d0); end else passed++;
    total++; if (rbyte !== 8'h3C) begin $display("FAIL ferr_byte_hold got=%h exp=3C", rbyte); end else passed++;
    total++; if (ferr_cnt - f0 !== 1) begin $display("FAIL ferr_count_after got=%0d exp=1", ferr_cnt - f0); end else passed++;
  endtask
  task automatic test_back_to_back;
    int d0 = dv_cnt, f0 = ferr_cnt, q0 = dv_q.size();
    logic [7:0] exp[3] = '{8'h00, 8'h55, 8'hC3};
    send_frame(8'h00, 1'b1, 8, 1'b1);
    send_frame(8'h55, 1'b1, 7, 1'b1);
    send_frame(8'hC3, 1'b1, 8, 1'b1);
    tick(10);
    total++; if (dv_cnt - d0 !== 3) begin $display("FAIL b2b_dv_count got=%0d exp=3", dv_cnt - d0); end else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if ((dv_q.size() > q0 + i ? dv_q[q0 + i] : 8'hxx) !== exp[i]) begin $display("FAIL b2b_byte%0d exp=%h", i, exp[i]); end else passed++;
    end
    total++; if (ferr_cnt - f0 !== 0 || both_cnt !== 0) begin $display("FAIL b2b_ferr got=%0d both=%0d exp=0", ferr_cnt - f0, both_cnt); end else passed++;
  endtask
  task automatic test_reset_mid;
    int d0 = dv_cnt, f0 = ferr_cnt;
    logic [7:0] b = 8'h81;
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(b[i], 8);
    send_bit(b[4], 4);
    rst = 1'b1;
    tick(1);
    total++; if (act !== 1'b0) begin $display("FAIL rstmid_active got=%b exp=0", act); end else passed++;
    total++; if (rbyte !== 8'h00) begin $display("FAIL rstmid_byte got=%h exp=00", rbyte); end else passed++;
    total++; if (dv !== 1'b0 || ferr !== 1'b0) begin $display("FAIL rstmid_strobes got dv=%b ferr=%b exp=0", dv, ferr); end else passed++;
    send_bit(b[4], 3);
    for (int i = 5; i < 8; i++) send_bit(b[i], 8);
    send_bit(1'b1, 8);
    rst = 1'b0;
    send_bit(1'b1, 10);
    total++; if (dv_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin $display("FAIL rstmid_no_strobe got dv=%0d ferr=%0d exp=0", dv_cnt - d0, ferr_cnt - f0); end else passed++;
    send_frame(8'h42, 1'b0, 8, 1'b1);
    tick(4);
    total++; if (dv_cnt - d0 !== 1) begin $display("FAIL rstmid_next_dv got=%0d exp=1", dv_cnt - d0); end else passed++;
    total++; if (rbyte !== 8'h42) begin $display("FAIL rstmid_next_byte got=%h exp=42", rbyte); end else passed++;
  endtask
  task automatic test_baud_104;
    int d0 = dv104_cnt, f0 = ferr104_cnt, k = cyc;
    logic [9:0] fr = {1'b1, 8'h0D, 1'b0};
    for (int i = 0; i < 10; i++) begin rx104 = fr[i]; tick(104); end
    tick(20);
    total++; if (dv104_cnt - d0 !== 1) begin $display("FAIL b104_dv_count got=%0d exp=1", dv104_cnt - d0); end else passed++;
    total++; if (rbyte104 !== 8'h0D) begin $display("FAIL b104_byte got=%h exp=0D", rbyte104); end else passed++;
    total++; if (dv104_cyc !== k + 991) begin $display("FAIL b104_dv_cycle got=%0d exp=%0d", dv104_cyc, k + 991); end else passed++;
    total++; if (ferr104_cnt - f0 !== 0) begin $display("FAIL b104_ferr got=%0d exp=0", ferr104_cnt - f0); end else passed++;
  endtask
  initial begin
    tick(1);
    test_reset;
    test_ideal;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_baud_104;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
